// File: rtl/fp_div_arbiter_pkg.sv
// fp_div_arbiter_pkg: shared state encoding and width constants for the divider arbiter
package fp_div_arbiter_pkg;
  localparam int NREQ_DEF = 4;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;
endpackage

// File: rtl/fp_div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, with wrap-around
module rr_arbiter
  import fp_div_arbiter_pkg::*;
#(
  parameter int N = NREQ_DEF,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [GW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] rot;
  logic [GW:0] off, sum;
  // rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner
  assign rot = N'({req_i, req_i} >> ptr_i);
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = (GW+1)'(k);
  end
  assign sum = {1'b0, ptr_i} + off;
  assign idx_o = GW'(sum >= (GW+1)'(N) ? sum - (GW+1)'(N) : sum);
  assign any_o = |req_i;
  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one handshaked float divider among NREQ requesters, one operation in flight
module fp_div_arbiter
  import fp_div_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int GW = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_a,
  input  logic [NREQ*WORD_W-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [WORD_W-1:0]        rsp_z,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [WORD_W-1:0]        div_a,
  output logic [WORD_W-1:0]        div_b,
  output logic                     div_stb_a,
  output logic                     div_stb_b,
  input  logic                     div_i_ack,
  input  logic [WORD_W-1:0]        div_z,
  input  logic                     div_z_stb,
  output logic                     div_z_ack,
  output logic                     busy,
  output logic [GW-1:0]            grant_id,
  output logic [15:0]              op_count
);
  state_t state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, gid_q, gid_d, gidx;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [NREQ-1:0] rv_q, rv_d, gnt;
  logic sa_q, sa_d, sb_q, sb_d, za_q, za_d, any;
  logic [15:0] cnt_q, cnt_d;
  rr_arbiter #(.N(NREQ), .GW(GW)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gidx),
    .any_o(any)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    a_d = a_q;
    b_d = b_q;
    z_d = z_q;
    rv_d = rv_q;
    sa_d = sa_q;
    sb_d = sb_q;
    za_d = za_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = SEND_A;
        gid_d = gidx;
        a_d = req_a[int'(gidx)*WORD_W +: WORD_W];
        b_d = req_b[int'(gidx)*WORD_W +: WORD_W];
        sa_d = 1'b1;
      end
      SEND_A: if (sa_q && div_i_ack) begin
        state_d = SEND_B;
        sa_d = 1'b0;
        sb_d = 1'b1;
      end
      SEND_B: if (sb_q && div_i_ack) begin
        state_d = WAIT_Z;
        sb_d = 1'b0;
        za_d = 1'b1;
      end
      WAIT_Z: if (za_q && div_z_stb) begin
        state_d = RESP;
        z_d = div_z;
        za_d = 1'b0;
        rv_d = NREQ'(1) << gid_q;
      end
      RESP: if (rsp_ready[gid_q]) begin
        state_d = IDLE;
        rv_d = '0;
        ptr_d = gid_q == GW'(NREQ - 1) ? '0 : gid_q + 1'b1;
        cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gid_q <= '0;
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      rv_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      za_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      a_q <= a_d;
      b_q <= b_d;
      z_q <= z_d;
      rv_q <= rv_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      za_q <= za_d;
      cnt_q <= cnt_d;
    end
  // acceptance is the only combinational output; masked so it stays low throughout reset
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign rsp_valid = rv_q;
  assign rsp_z = z_q;
  assign div_a = a_q;
  assign div_b = b_q;
  assign div_stb_a = sa_q;
  assign div_stb_b = sb_q;
  assign div_z_ack = za_q;
  assign busy = state_q != IDLE;
  assign grant_id = gid_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed bench with divider emulator, per-cycle reference model and literal checks
module tb_fp_div_arbiter;
  localparam int N = 4;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0] rsp_z, div_a, div_b, div_z;
  logic div_stb_a, div_stb_b, div_i_ack, div_z_stb, div_z_ack, busy;
  logic [1:0] grant_id;
  logic [15:0] op_count;
  int checks = 0, failures = 0;
  int order[$];
  logic [31:0] got_z[$];

  fp_div_arbiter #(.NREQ(N), .GW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .div_a(div_a), .div_b(div_b), .div_stb_a(div_stb_a), .div_stb_b(div_stb_b),
    .div_i_ack(div_i_ack), .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
    .busy(busy), .grant_id(grant_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // IEEE-754 single quotients of the operand pairs used here, worked out by hand
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h00000000}: return 32'h7F800000;
      {32'h00000000, 32'h00000000}: return 32'hFFC00000;
      {32'h41000000, 32'h40000000}: return 32'h40800000;
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      {32'h41100000, 32'h40400000}: return 32'h40400000;
      {32'h41200000, 32'h40800000}: return 32'h40200000;
      {32'h40800000, 32'h3F800000}: return 32'h40800000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // divider emulator: acks operand strobes at once, returns the quotient LAT cycles into WAIT_Z
  initial begin
    int cnt;
    cnt = 0;
    div_i_ack = 1'b0;
    div_z_stb = 1'b0;
    div_z = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        div_i_ack = 1'b0;
        div_z_stb = 1'b0;
      end else begin
        div_i_ack = div_stb_a | div_stb_b;
        if (div_z_ack) begin
          cnt++;
          if (cnt >= LAT) begin
            div_z_stb = 1'b1;
            div_z = ref_div(div_a, div_b);
          end
        end else begin
          cnt = 0;
          div_z_stb = 1'b0;
        end
      end
    end
  end

  // reference model: at most one owner, round-robin from m_ptr, result = quotient of accepted operands
  initial begin
    int m_ptr, m_cnt, m_owner;
    bit m_busy;
    logic [31:0] m_a, m_b, m_z;
    logic [N-1:0] exp_rdy;
    m_ptr = 0; m_cnt = 0; m_owner = 0; m_busy = 0;
    m_a = '0; m_b = '0; m_z = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ptr = 0; m_cnt = 0; m_busy = 0;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_strobes", {div_stb_a, div_stb_b, div_z_ack}, 0);
      end else begin
        exp_rdy = '0;
        if (!m_busy)
          for (int k = N - 1; k >= 0; k--)
            if (req_valid[(m_ptr + k) % N]) exp_rdy = N'(1) << ((m_ptr + k) % N);
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, m_busy);
        chk("op_count", op_count, m_cnt);
        if (m_busy) begin
          chk("grant_id", grant_id, m_owner);
          chk("div_a", div_a, m_a);
          chk("div_b", div_b, m_b);
          if (rsp_valid != 0) begin
            chk("rsp_valid", rsp_valid, N'(1) << m_owner);
            chk("rsp_z", rsp_z, m_z);
          end
        end else chk("rsp_valid_idle", rsp_valid, 0);
        if (!m_busy && (exp_rdy & req_valid) != 0) begin
          m_busy = 1;
          for (int i = 0; i < N; i++) if (exp_rdy[i]) m_owner = i;
          m_a = req_a[32*m_owner +: 32];
          m_b = req_b[32*m_owner +: 32];
          m_z = ref_div(m_a, m_b);
        end else if (m_busy && rsp_valid[m_owner] && rsp_ready[m_owner]) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % N;
          m_cnt = (m_cnt + 1) & 16'hFFFF;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  // drop each accepted req_valid, take each response after `hold` cycles, log grant order and results
  task automatic serve(input int nops, input int hold);
    int done, held, cyc;
    bit go;
    logic [N-1:0] acc, rv;
    logic [31:0] z0;
    done = 0; held = 0; cyc = 0; z0 = '0;
    order.delete();
    got_z.delete();
    while (done < nops && cyc < 500) begin
      @(negedge clk);
      cyc++;
      acc = req_ready & req_valid;
      rv = rsp_valid;
      go = 0;
      for (int i = 0; i < N; i++) if (acc[i]) order.push_back(i);
      if (rv != 0 && rsp_ready == 0) begin
        if (held == 0) z0 = rsp_z;
        else begin
          chk("hold_rsp_z", rsp_z, z0);
          chk("hold_rsp_valid", rsp_valid, rv);
          chk("hold_busy", busy, 1);
          chk("hold_no_ready", req_ready, 0);
        end
        held++;
        go = held > hold;
      end
      if (go) begin
        got_z.push_back(rsp_z);
        done++;
        held = 0;
      end
      tick();
      req_valid = req_valid & ~acc;
      rsp_ready = go ? rv : '0;
    end
    if (done < nops) chk("serve_timeout", done, nops);
    tick();
    rsp_ready = '0;
  endtask

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_grant_id", grant_id, 0);
    tick();
    setop(1, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0010;
    serve(1, 0);
    chk("t1_grant", order.size() > 0 ? order[0] : -1, 1);
    chk("t1_z", got_z.size() > 0 ? got_z[0] : 0, 32'h40400000);
    @(negedge clk);
    chk("t1_count", op_count, 1);
    chk("t1_grant_id", grant_id, 1);
    tick();
    setop(0, 32'h3F800000, 32'h00000000);
    req_valid = 4'b0001;
    serve(1, 0);
    chk("t2_inf", got_z.size() > 0 ? got_z[0] : 0, 32'h7F800000);
    setop(0, 32'h00000000, 32'h00000000);
    req_valid = 4'b0001;
    serve(1, 0);
    chk("t2_nan", got_z.size() > 0 ? got_z[0] : 0, 32'hFFC00000);
    @(negedge clk);
    chk("t2_count", op_count, 3);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    setop(0, 32'h41000000, 32'h40000000);
    setop(1, 32'h3F800000, 32'h40000000);
    setop(2, 32'h41100000, 32'h40400000);
    setop(3, 32'h41200000, 32'h40800000);
    req_valid = 4'b1111;
    serve(4, 0);
    for (int i = 0; i < 4; i++) chk("t3_order", order.size() > i ? order[i] : -1, i);
    chk("t3_z0", got_z.size() > 0 ? got_z[0] : 0, 32'h40800000);
    chk("t3_z1", got_z.size() > 1 ? got_z[1] : 0, 32'h3F000000);
    chk("t3_z2", got_z.size() > 2 ? got_z[2] : 0, 32'h40400000);
    chk("t3_z3", got_z.size() > 3 ? got_z[3] : 0, 32'h40200000);
    @(negedge clk);
    chk("t3_count", op_count, 4);
    tick();
    setop(0, 32'h40800000, 32'h3F800000);
    setop(2, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0101;
    serve(2, 10);
    chk("t4_order0", order.size() > 0 ? order[0] : -1, 0);
    chk("t4_order1", order.size() > 1 ? order[1] : -1, 2);
    chk("t4_z0", got_z.size() > 0 ? got_z[0] : 0, 32'h40800000);
    chk("t4_z1", got_z.size() > 1 ? got_z[1] : 0, 32'h40400000);
    @(negedge clk);
    chk("t4_count", op_count, 6);
    tick();
    setop(3, 32'h41200000, 32'h40800000);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!div_z_ack && n < 20);
      chk("t5_reach_wait_z", div_z_ack, 1);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_rsp_valid", rsp_valid, 0);
    chk("t5_async_zack", div_z_ack, 0);
    chk("t5_async_stb", {div_stb_a, div_stb_b}, 0);
    chk("t5_async_count", op_count, 0);
    chk("t5_async_grant_id", grant_id, 0);
    chk("t5_async_rsp_z", rsp_z, 0);
    chk("t5_async_req_ready", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    setop(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    serve(1, 0);
    chk("t5_grant", order.size() > 0 ? order[0] : -1, 0);
    chk("t5_z", got_z.size() > 0 ? got_z[0] : 0, 32'h3F000000);
    @(negedge clk);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_count", op_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
